// File: rtl/qif_neuron_array_if.sv
// Handshake and data bundle for qif_neuron_array: synaptic drive in, membrane/spike out.
// master drives tick/ch_en/i_syn; slave (the neuron array) drives the results.
interface qif_neuron_array_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned W    = 8
);
  logic              tick;
  logic [N_CH-1:0]   ch_en;
  logic [N_CH*W-1:0] i_syn;
  logic [N_CH*W-1:0] v_mem;
  logic [N_CH-1:0]   spike;
  logic              busy;
  logic              done;

  modport master (
    output tick, ch_en, i_syn,
    input  v_mem, spike, busy, done
  );

  modport slave (
    input  tick, ch_en, i_syn,
    output v_mem, spike, busy, done
  );
endinterface

// File: rtl/qif_neuron_array.sv
// Time-multiplexed quadratic integrate-and-fire array: one shared square/accumulate
// datapath sweeps N_CH membranes round-robin, one channel per clock, per accepted tick.
module qif_neuron_array #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned W        = 8,
  parameter int unsigned SQ_SHIFT = 4,
  parameter int unsigned V_TH     = 200,
  parameter int unsigned V_RESET  = 0,
  parameter int unsigned LEAK     = 1,
  parameter int unsigned REFRACT  = 2
) (
  input logic                 clk,
  input logic                 rst,
  qif_neuron_array_if.slave   bus
);

  localparam int unsigned IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  // Wide enough that V + V^2 + I cannot overflow and V - LEAK shows up as negative.
  localparam int unsigned SW = 2 * W + 2;
  localparam logic [W-1:0] VMax = '1;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e            state_q;
  logic [IW-1:0]     idx_q;
  logic [W-1:0]      v_q   [N_CH];
  logic [RW-1:0]     ref_q [N_CH];
  logic [N_CH*W-1:0] syn_lat_q;
  logic [N_CH-1:0]   en_lat_q;
  logic [N_CH-1:0]   acc_q;
  logic [N_CH-1:0]   spike_q;
  logic              busy_q;
  logic              done_q;

  logic [W-1:0]      v_cur, i_cur, s_clamp, v_nxt;
  logic [RW-1:0]     ref_cur, ref_nxt;
  logic              en_cur, flag;
  logic [SW-1:0]     v_ext, i_ext, sq, sum;
  logic [N_CH-1:0]   acc_upd;
  logic [N_CH*W-1:0] v_flat;

  always_comb begin
    v_cur   = v_q[idx_q];
    ref_cur = ref_q[idx_q];
    i_cur   = '0;
    en_cur  = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (idx_q == IW'(c)) begin
        i_cur  = syn_lat_q[c*W +: W];
        en_cur = en_lat_q[c];
      end
    end

    v_ext = SW'(v_cur);
    i_ext = SW'(i_cur);
    sq    = (v_ext * v_ext) >> SQ_SHIFT;
    sum   = v_ext + sq + i_ext - SW'(LEAK);

    // Sign bit set means the leak drove the sum below zero.
    if (sum[SW-1]) begin
      s_clamp = '0;
    end else if (sum > SW'(VMax)) begin
      s_clamp = VMax;
    end else begin
      s_clamp = sum[W-1:0];
    end

    v_nxt   = v_cur;
    ref_nxt = ref_cur;
    flag    = 1'b0;
    if (en_cur) begin
      if (ref_cur != '0) begin
        ref_nxt = ref_cur - 1'b1;
        v_nxt   = W'(V_RESET);
      end else if (s_clamp >= W'(V_TH)) begin
        v_nxt   = W'(V_RESET);
        ref_nxt = RW'(REFRACT);
        flag    = 1'b1;
      end else begin
        v_nxt = s_clamp;
      end
    end

    acc_upd        = acc_q;
    acc_upd[idx_q] = flag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      syn_lat_q <= '0;
      en_lat_q  <= '0;
      acc_q     <= '0;
      spike_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        v_q[c]   <= '0;
        ref_q[c] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.tick) begin
            syn_lat_q <= bus.i_syn;
            en_lat_q  <= bus.ch_en;
            idx_q     <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= StSweep;
          end
        end
        StSweep: begin
          v_q[idx_q]   <= v_nxt;
          ref_q[idx_q] <= ref_nxt;
          acc_q        <= acc_upd;
          if (idx_q == IW'(N_CH - 1)) begin
            spike_q <= acc_upd;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    v_flat = '0;
    for (int c = 0; c < N_CH; c++) begin
      v_flat[c*W +: W] = v_q[c];
    end
  end

  assign bus.v_mem = v_flat;
  assign bus.spike = spike_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
